// File: rtl/switch_btn_capture_pkg.sv
// switch_btn_capture_pkg: shared build constants and board bit positions for the switch/button capture path
package switch_btn_capture_pkg;
    localparam int DEBOUNCE_HW     = 1000000;
    localparam int DEBOUNCE_SIM    = 4;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int SW0  = 0;
    localparam int SW1  = 1;
    localparam int BTN0 = 2;
    localparam int BTN1 = 3;
endpackage

// File: rtl/switch_btn_capture_debounce_bit.sv
// debounce_bit: synchronizes, debounces and edge-detects one raw input bit
//   clk, rst : clock, asynchronous active-high reset
//   in       : raw level, asynchronous to clk
//   stable   : debounced level
//   rise/fall: one-cycle pulses following a stable transition
//   toggle   : combinational, high on the edge where stable is about to change
module debounce_bit
    import switch_btn_capture_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_HW,
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic stable,
    output logic rise,
    output logic fall,
    output logic toggle
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          count;
    logic                   sync_out;
    assign sync_out = sync[SYNC_STAGES-1];
    // accept once the mismatch has been seen on DEBOUNCE_CYCLES consecutive edges
    assign toggle = (sync_out != stable) && (count == CW'(DEBOUNCE_CYCLES - 1));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync   <= '0;
            count  <= '0;
            stable <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync   <= {sync[SYNC_STAGES-2:0], in};
            count  <= (sync_out == stable || toggle) ? '0 : count + CW'(1);
            stable <= stable ^ toggle;
            rise   <= toggle & ~stable;
            fall   <= toggle & stable;
        end
    end
endmodule

// File: rtl/switch_btn_capture.sv
// switch_btn_capture: debounced switch/button capture with sticky change flags and maskable interrupt
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_in         : raw switch/button levels
//   i_ack        : write-1-to-clear for o_changed
//   i_irq_mask   : per-bit interrupt enable
//   o_stable     : debounced levels
//   o_rise/o_fall: one-cycle edge pulses per bit
//   o_changed    : sticky per-bit change flags
//   o_irq        : registered OR of enabled change flags
module switch_btn_capture
    import switch_btn_capture_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_HW,
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_in,
    input  logic [WIDTH-1:0] i_ack,
    input  logic [WIDTH-1:0] i_irq_mask,
    output logic [WIDTH-1:0] o_stable,
    output logic [WIDTH-1:0] o_rise,
    output logic [WIDTH-1:0] o_fall,
    output logic [WIDTH-1:0] o_changed,
    output logic             o_irq
);
    logic [WIDTH-1:0] toggle;
    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .SYNC_STAGES    (SYNC_STAGES)
        ) u_bit (
            .clk   (i_clk),
            .rst   (i_rst),
            .in    (i_in[g]),
            .stable(o_stable[g]),
            .rise  (o_rise[g]),
            .fall  (o_fall[g]),
            .toggle(toggle[g])
        );
    end
    // a new change outranks an acknowledge arriving in the same cycle
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_changed <= '0;
            o_irq     <= 1'b0;
        end else begin
            o_changed <= (o_changed & ~i_ack) | toggle;
            o_irq     <= |(o_changed & i_irq_mask);
        end
    end
endmodule

// File: tb/tb_switch_btn_capture.sv
// tb_switch_btn_capture: directed and random checks of switch_btn_capture against a reference model
module tb_switch_btn_capture;
    import switch_btn_capture_pkg::*;
    localparam int W = 4;
    localparam int D = DEBOUNCE_SIM;
    localparam int S = SYNC_STAGES_DEF;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [W-1:0] in = '0, ack = '0, mask = '0;
    logic [W-1:0] o_stable, o_rise, o_fall, o_changed;
    logic o_irq;
    always #5 clk = ~clk;
    switch_btn_capture #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .SYNC_STAGES(S)) dut (
        .i_clk(clk), .i_rst(rst), .i_in(in), .i_ack(ack), .i_irq_mask(mask),
        .o_stable(o_stable), .o_rise(o_rise), .o_fall(o_fall),
        .o_changed(o_changed), .o_irq(o_irq)
    );
    // raw samples per edge, newest first; sync output at an edge is the sample S edges old
    logic [W-1:0] hist [S+D];
    logic [W-1:0] m_stable, m_rise, m_fall, m_changed;
    logic m_irq;
    int vectors = 0;
    int miscompares = 0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic model_reset();
        for (int i = 0; i < S + D; i++) hist[i] = '0;
        m_stable = '0; m_rise = '0; m_fall = '0; m_changed = '0; m_irq = 1'b0;
    endtask
    // a bit flips once its synchronized level has disagreed on the last D edges
    task automatic model_edge();
        logic [W-1:0] upd;
        for (int i = S + D - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = in;
        for (int b = 0; b < W; b++) begin
            upd[b] = 1'b1;
            for (int k = S; k < S + D; k++) if (hist[k][b] == m_stable[b]) upd[b] = 1'b0;
        end
        m_irq     = |(m_changed & mask);
        m_rise    = upd & ~m_stable;
        m_fall    = upd & m_stable;
        m_stable  = m_stable ^ upd;
        m_changed = (m_changed & ~ack) | upd;
    endtask
    task automatic compare_all();
        check("stable", 32'(o_stable), 32'(m_stable));
        check("rise", 32'(o_rise), 32'(m_rise));
        check("fall", 32'(o_fall), 32'(m_fall));
        check("changed", 32'(o_changed), 32'(m_changed));
        check("irq", 32'(o_irq), 32'(m_irq));
        check("rise_fall_excl", 32'(o_rise & o_fall), 32'(0));
    endtask
    task automatic step(input logic [W-1:0] i_v, input logic [W-1:0] a_v, input logic [W-1:0] m_v);
        in = i_v; ack = a_v; mask = m_v;
        @(posedge clk);
        model_edge();
        #1 compare_all();
        @(negedge clk);
    endtask
    task automatic hold(input logic [W-1:0] i_v, input logic [W-1:0] m_v, input int n);
        for (int i = 0; i < n; i++) step(i_v, '0, m_v);
    endtask
    initial begin
        int rises, first;
        model_reset();
        #1 compare_all();
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        // clean press on BTN0
        hold(4'b0100, 4'b0100, 5);
        check("press_not_yet", 32'(o_stable[BTN0]), 32'(0));
        step(4'b0100, '0, 4'b0100);
        check("press_stable", 32'(o_stable[BTN0]), 32'(1));
        check("press_rise", 32'(o_rise), 32'(4'b0100));
        check("press_irq_lag", 32'(o_irq), 32'(0));
        step(4'b0100, '0, 4'b0100);
        check("press_rise_gone", 32'(o_rise), 32'(0));
        check("press_irq", 32'(o_irq), 32'(1));
        // bounce on SW0, then settle high
        rises = 0; first = -1;
        for (int i = 0; i < 14; i++) begin
            step({3'b010, (i >= 8) ? 1'b1 : ((i % 4) < 2)}, '0, 4'b0100);
            rises += o_rise[SW0];
            if (first < 0 && o_stable[SW0]) first = i;
        end
        check("bounce_settle_edge", 32'(first), 32'(13));
        check("bounce_one_rise", 32'(rises), 32'(1));
        // acknowledge SW1, then collide an ack with its fall
        hold(4'b0111, 4'b0010, 6);
        check("sw1_changed", 32'(o_changed[SW1]), 32'(1));
        step(4'b0111, 4'b0111, 4'b0010);
        check("ack_clears", 32'(o_changed[SW1]), 32'(0));
        check("ack_irq_still", 32'(o_irq), 32'(1));
        step(4'b0111, '0, 4'b0010);
        check("ack_irq_drop", 32'(o_irq), 32'(0));
        hold(4'b0101, 4'b0010, 5);
        step(4'b0101, 4'b0010, 4'b0010);
        check("collide_fall", 32'(o_fall[SW1]), 32'(1));
        check("collide_changed", 32'(o_changed[SW1]), 32'(1));
        // masked release of BTN1
        hold(4'b1101, '0, 6);
        step(4'b1101, 4'b1111, '0);
        hold(4'b0101, '0, 6);
        check("mask_changed", 32'(o_changed[BTN1]), 32'(1));
        check("mask_irq_off", 32'(o_irq), 32'(0));
        step(4'b0101, '0, 4'b1000);
        check("mask_irq_on", 32'(o_irq), 32'(1));
        // reset mid-count
        hold(4'b0000, '0, 6);
        step(4'b0000, 4'b1111, '0);
        hold(4'b1111, '0, 4);
        rst = 1'b1;
        model_reset();
        #1 compare_all();
        check("rst_all_zero", 32'({o_stable, o_rise, o_fall, o_changed, o_irq}), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        hold(4'b1111, '0, 5);
        check("rst_not_yet", 32'(o_stable), 32'(0));
        step(4'b1111, '0, '0);
        check("rst_reaccept", 32'(o_stable), 32'(4'b1111));
        check("rst_changed", 32'(o_changed), 32'(4'b1111));
        // simultaneous multi-bit press
        hold(4'b0000, '0, 6);
        step(4'b0000, 4'b1111, '0);
        hold(4'b0101, '0, 5);
        step(4'b0101, '0, '0);
        check("multi_rise", 32'(o_rise), 32'(4'b0101));
        check("multi_changed", 32'(o_changed), 32'(4'b0101));
        check("multi_no_fall", 32'(o_fall), 32'(0));
        // random traffic with long-ish holds so both accepts and rejects occur
        for (int i = 0; i < 2000; i++) begin
            logic [W-1:0] nxt;
            nxt = in;
            for (int b = 0; b < W; b++) if ($urandom_range(5) == 0) nxt[b] = ~nxt[b];
            step(nxt, ($urandom_range(3) == 0) ? W'($urandom) : '0, W'($urandom));
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
